// File: rtl/reduction_pkg.sv
// Shared constants and state encoding for the Reduction_B layer controller.
package reduction_pkg;

    // Kernel words loaded per channel: 1+9+1+9+1+9+9.
    localparam int unsigned NUM_WT = 39;

    // Width of the kernel-slot index presented to the weight bank.
    localparam int unsigned WT_IDX_W = 6;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/reduction_b_ctrl.sv
// Reduction_B layer controller: per channel, fetches the kernel words, then streams
// one IMG_W x IMG_W map into the datapath; after the last channel waits for every
// datapath output beat before signalling completion.
module reduction_b_ctrl
    import reduction_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_W      = 17,
    parameter int unsigned N_CH       = 1088,
    parameter int unsigned OUT_PER_CH = 256,
    localparam int unsigned ADDR_W    = $clog2(N_CH * NUM_WT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    input  logic [DATA_WIDTH-1:0] src_pxl_i,
    output logic                  dp_valid_in_o,
    output logic [DATA_WIDTH-1:0] dp_pxl_in_o,
    input  logic                  dp_valid_out_i,
    output logic                  wt_req_o,
    output logic [ADDR_W-1:0]     wt_addr_o,
    input  logic                  wt_ack_i,
    output logic [WT_IDX_W-1:0]   wt_idx_o
);

    localparam int unsigned PIX_TOTAL = IMG_W * IMG_W;
    localparam int unsigned OUT_TOTAL = N_CH * OUT_PER_CH;
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PIX_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam int unsigned CNT_W     = $clog2(OUT_TOTAL + 1);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [WT_IDX_W-1:0]   idx_q, idx_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  err_q, err_d;
    logic                  dp_valid_q;
    logic [DATA_WIDTH-1:0] dp_pxl_q;

    logic start_ok;
    logic xfer;
    logic cnt_full;

    assign start_ok    = (state_q == StIdle) && start_i;
    assign src_ready_o = (state_q == StStream);
    assign xfer        = src_valid_i && src_ready_o;
    assign cnt_full    = (out_cnt_q == CNT_W'(OUT_TOTAL));

    // Output-beat counter (saturating) and sticky overflow flag.
    always_comb begin
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        if (start_ok) begin
            out_cnt_d = '0;
            err_d     = 1'b0;
        end else if (dp_valid_out_i) begin
            if (state_q == StIdle || cnt_full) begin
                err_d = 1'b1;
            end
            if (state_q != StIdle && !cnt_full) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
    end

    // Run sequencing: weight load, pixel stream per channel, then drain.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    ch_d    = '0;
                    idx_d   = '0;
                    pix_d   = '0;
                end
            end
            StLoad: begin
                if (wt_ack_i) begin
                    if (idx_q == WT_IDX_W'(NUM_WT - 1)) begin
                        idx_d   = '0;
                        state_d = StStream;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (xfer) begin
                    if (pix_q == PIX_W'(PIX_TOTAL - 1)) begin
                        pix_d = '0;
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            state_d = StDrain;
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = StLoad;
                        end
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // A final beat arriving this cycle already completes the run.
                if (out_cnt_d == CNT_W'(OUT_TOTAL)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            idx_q     <= '0;
            pix_q     <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            idx_q     <= idx_d;
            pix_q     <= pix_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    // One-cycle register stage between the upstream handshake and the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid_q <= 1'b0;
            dp_pxl_q   <= '0;
        end else begin
            dp_valid_q <= xfer;
            if (xfer) begin
                dp_pxl_q <= src_pxl_i;
            end
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign err_o         = err_q;
    assign dp_valid_in_o = dp_valid_q;
    assign dp_pxl_in_o   = dp_pxl_q;
    assign wt_req_o      = (state_q == StLoad);
    assign wt_idx_o      = idx_q;
    assign wt_addr_o     = ADDR_W'(ch_q) * ADDR_W'(NUM_WT) + ADDR_W'(idx_q);

endmodule

// File: tb/tb_reduction_b_ctrl.sv
// Randomized scoreboard bench for reduction_b_ctrl (IMG_W=3, N_CH=2, OUT_PER_CH=4).
module tb_reduction_b_ctrl;

    localparam int DW          = 32;
    localparam int IMG_W       = 3;
    localparam int N_CH        = 2;
    localparam int OUT_PER_CH  = 4;
    localparam int NUM_WT      = 39;
    localparam int AW          = $clog2(N_CH * NUM_WT);
    localparam int PIX_PER_RUN = IMG_W * IMG_W * N_CH;
    localparam int BEATS_TOTAL = N_CH * OUT_PER_CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic          src_valid_i = 1'b0;
    logic [DW-1:0] src_pxl_i = '0;
    logic          dp_valid_out_i = 1'b0;
    logic          wt_ack_i = 1'b0;
    logic          busy_o, done_o, err_o, src_ready_o, dp_valid_in_o, wt_req_o;
    logic [DW-1:0] dp_pxl_in_o;
    logic [AW-1:0] wt_addr_o;
    logic [5:0]    wt_idx_o;

    typedef struct {
        int addr;
        int idx;
    } wt_exp_t;

    wt_exp_t       exp_wt[$];
    logic [DW-1:0] exp_pxl[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            dp_pulses = 0;

    reduction_b_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_W     (IMG_W),
        .N_CH      (N_CH),
        .OUT_PER_CH(OUT_PER_CH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .src_pxl_i     (src_pxl_i),
        .dp_valid_in_o (dp_valid_in_o),
        .dp_pxl_in_o   (dp_pxl_in_o),
        .dp_valid_out_i(dp_valid_out_i),
        .wt_req_o      (wt_req_o),
        .wt_addr_o     (wt_addr_o),
        .wt_ack_i      (wt_ack_i),
        .wt_idx_o      (wt_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    // Monitor: pops the expected weight words and pixels as the DUT presents them.
    initial begin : monitor
        bit            prev_xfer;
        bit            prev_hold;
        logic [AW-1:0] prev_addr;
        logic [5:0]    prev_idx;
        wt_exp_t       e;
        prev_xfer = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        prev_idx  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_xfer = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (dp_valid_in_o || prev_xfer)
                    check("dp_valid_in_delay", dp_valid_in_o, prev_xfer);
                if (dp_valid_in_o) begin
                    dp_pulses++;
                    if (exp_pxl.size() == 0) fail_now("dp_pxl_in", "unexpected pixel");
                    else check("dp_pxl_in", dp_pxl_in_o, exp_pxl.pop_front());
                end
                if (wt_req_o) begin
                    check("src_ready_in_load", src_ready_o, 1'b0);
                    if (prev_hold) begin
                        check("wt_addr_stable", wt_addr_o, prev_addr);
                        check("wt_idx_stable", wt_idx_o, prev_idx);
                    end
                    if (wt_ack_i) begin
                        if (exp_wt.size() == 0) begin
                            fail_now("wt_addr", "unexpected weight fetch");
                        end else begin
                            e = exp_wt.pop_front();
                            check("wt_addr", wt_addr_o, e.addr);
                            check("wt_idx", wt_idx_o, e.idx);
                        end
                    end
                end
                prev_xfer = src_valid_i && src_ready_o;
                prev_hold = wt_req_o && !wt_ack_i;
                prev_addr = wt_addr_o;
                prev_idx  = wt_idx_o;
            end
        end
    end

    task automatic idle_inputs();
        start_i        = 1'b0;
        src_valid_i    = 1'b0;
        wt_ack_i       = 1'b0;
        dp_valid_out_i = 1'b0;
    endtask

    task automatic apply_reset_mid();
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_outputs_zero",
              {busy_o, done_o, err_o, src_ready_o, dp_valid_in_o, wt_req_o,
               dp_pxl_in_o, wt_addr_o, wt_idx_o}, '0);
        idle_inputs();
        repeat (2) @(negedge clk);
        exp_wt.delete();
        exp_pxl.delete();
        rst_n = 1'b1;
    endtask

    // One layer run; the model is the spec's ordering: every (ch, slot) word in turn,
    // pixels in acceptance order, exactly one done after all beats.
    task automatic run_one(input int ack_every, input int src_mode, input int beats,
                           input bit mid_start, input bit do_reset);
        int cyc, beats_left, xfers, done_cnt, pulses0, ack_ctr;
        bit saw_done, prev_done, mid_sent;
        cyc = 0; beats_left = beats; xfers = 0; done_cnt = 0; ack_ctr = 0;
        saw_done = 1'b0; prev_done = 1'b0; mid_sent = 1'b0;
        pulses0 = dp_pulses;
        @(negedge clk);
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < NUM_WT; i++)
                exp_wt.push_back('{addr: c * NUM_WT + i, idx: i});
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("err_after_start", err_o, 1'b0);
        check("busy_after_start", busy_o, 1'b1);
        forever begin
            ack_ctr++;
            wt_ack_i = (ack_ctr % ack_every) == 0;
            case (src_mode)
                0:       src_valid_i = 1'b1;
                1:       src_valid_i = (cyc % 2) == 0;
                default: src_valid_i = $urandom_range(0, 1) == 1;
            endcase
            src_pxl_i      = $urandom;
            dp_valid_out_i = (beats_left > 0) && ($urandom_range(0, 3) == 0);
            if (dp_valid_out_i) beats_left--;
            start_i = mid_start && !mid_sent && src_ready_o && xfers == 3;
            if (start_i) mid_sent = 1'b1;
            if (src_valid_i && src_ready_o) begin
                exp_pxl.push_back(src_pxl_i);
                xfers++;
                if (do_reset && xfers == 5) begin
                    apply_reset_mid();
                    return;
                end
            end
            @(negedge clk);
            cyc++;
            if (prev_done) check("busy_low_after_done", busy_o, 1'b0);
            prev_done = done_o;
            if (done_o) begin
                done_cnt++;
                saw_done = 1'b1;
                check("beats_before_done", (beats - beats_left) >= BEATS_TOTAL, 1'b1);
            end
            if (saw_done && beats_left == 0 && !busy_o) break;
            if (cyc > 5000) begin
                fail_now("run_timeout", "no completion within 5000 cycles");
                break;
            end
        end
        idle_inputs();
        @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("pixels_transferred", xfers, PIX_PER_RUN);
        check("dp_valid_in_pulses", dp_pulses - pulses0, PIX_PER_RUN);
        check("wt_words_left", exp_wt.size(), 0);
        check("pixels_left", exp_pxl.size(), 0);
        check("err_final", err_o, beats > BEATS_TOTAL);
        exp_wt.delete();
        exp_pxl.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs_zero",
              {busy_o, done_o, err_o, src_ready_o, dp_valid_in_o, wt_req_o,
               dp_pxl_in_o, wt_addr_o, wt_idx_o}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(1, 0, 8, 1'b0, 1'b0);   // nominal
        run_one(1, 1, 8, 1'b0, 1'b0);   // alternating src_valid
        run_one(3, 0, 8, 1'b0, 1'b0);   // slow weight ack
        run_one(1, 2, 9, 1'b0, 1'b0);   // one beat too many
        run_one(1, 0, 8, 1'b0, 1'b0);   // err cleared by this start
        run_one(1, 0, 8, 1'b0, 1'b1);   // reset at 5th pixel of ch 0
        run_one(1, 0, 8, 1'b0, 1'b0);   // restart from address 0
        run_one(2, 2, 8, 1'b1, 1'b0);   // start pulsed during stream
        for (int r = 0; r < 3; r++)
            run_one($urandom_range(1, 3), 2, $urandom_range(8, 9), 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
